// File: rtl/csr_unit.sv
// Machine-mode CSR file: trap/mret state, interrupt pending/enable, and optional
// 64-bit mcycle/minstret counters (enabled by defining CSR_COUNTERS_EN).
module csr_unit #(
  parameter logic [31:0] MHARTID = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] read_address,
  output logic [31:0] read_data,
  input  logic        csr_write,
  input  logic [11:0] csr_address,
  input  logic [31:0] csr_data,
  input  logic        traped,
  input  logic        mret,
  input  logic        retired,
  input  logic [31:0] ecp,
  input  logic [3:0]  ecause,
  input  logic        interupt,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        soft_irq,
  output logic        eip,
  output logic        tip,
  output logic        sip,
  output logic [31:0] trap_vector,
  output logic [31:0] mret_vector
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MHARTID   = 12'hF14;
  localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;

  logic        mstatus_mie, mstatus_mpie;
  logic        mie_msie, mie_mtie, mie_meie;
  logic        mip_msip, mip_mtip, mip_meip;
  logic [29:0] mtvec_base;
  logic [31:0] mscratch;
  logic [29:0] mepc_word;
  logic        mcause_int;
  logic [3:0]  mcause_code;

  logic [31:0] mstatus_rd, mie_rd, mip_rd, mcause_rd;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign mie_rd     = {20'b0, mie_meie, 3'b0, mie_mtie, 3'b0, mie_msie, 3'b0};
  assign mip_rd     = {20'b0, mip_meip, 3'b0, mip_mtip, 3'b0, mip_msip, 3'b0};
  assign mcause_rd  = {mcause_int, 27'b0, mcause_code};

  assign eip         = mip_meip & mie_meie & mstatus_mie;
  assign tip         = mip_mtip & mie_mtie & mstatus_mie;
  assign sip         = mip_msip & mie_msie & mstatus_mie;
  assign trap_vector = {mtvec_base, 2'b00};
  assign mret_vector = {mepc_word, 2'b00};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_msie     <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mip_msip     <= 1'b0;
      mip_mtip     <= 1'b0;
      mip_meip     <= 1'b0;
      mtvec_base   <= '0;
      mscratch     <= '0;
      mepc_word    <= '0;
      mcause_int   <= 1'b0;
      mcause_code  <= '0;
    end else begin
      mip_msip <= soft_irq;
      mip_mtip <= timer_irq;
      mip_meip <= ext_irq;

      if (csr_write && csr_address == A_MIE) begin
        mie_msie <= csr_data[3];
        mie_mtie <= csr_data[7];
        mie_meie <= csr_data[11];
      end
      if (csr_write && csr_address == A_MTVEC)    mtvec_base <= csr_data[31:2];
      if (csr_write && csr_address == A_MSCRATCH) mscratch   <= csr_data;

      // Trap beats mret beats software write on the shared mstatus/mepc/mcause fields.
      if (traped) begin
        mepc_word    <= ecp[31:2];
        mcause_int   <= interupt;
        mcause_code  <= ecause;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else begin
        if (mret) begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
        end else if (csr_write && csr_address == A_MSTATUS) begin
          mstatus_mie  <= csr_data[3];
          mstatus_mpie <= csr_data[7];
        end
        if (csr_write && csr_address == A_MEPC) mepc_word <= csr_data[31:2];
        if (csr_write && csr_address == A_MCAUSE) begin
          mcause_int  <= csr_data[31];
          mcause_code <= csr_data[3:0];
        end
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [31:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;
  logic        cyc_lo_wr, cyc_hi_wr, ins_lo_wr, ins_hi_wr;
  logic        cyc_carry, ins_carry;

  assign cyc_lo_wr = csr_write && csr_address == 12'hB00;
  assign cyc_hi_wr = csr_write && csr_address == 12'hB80;
  assign ins_lo_wr = csr_write && csr_address == 12'hB02;
  assign ins_hi_wr = csr_write && csr_address == 12'hB82;

  // A written low half never carries; the high half still sees carries otherwise.
  assign cyc_carry = !cyc_lo_wr && (mcycle_lo == 32'hFFFF_FFFF);
  assign ins_carry = !ins_lo_wr && retired && (minstret_lo == 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_lo   <= '0;
      mcycle_hi   <= '0;
      minstret_lo <= '0;
      minstret_hi <= '0;
    end else begin
      mcycle_lo   <= cyc_lo_wr ? csr_data : mcycle_lo + 32'd1;
      mcycle_hi   <= cyc_hi_wr ? csr_data : mcycle_hi + {31'b0, cyc_carry};
      minstret_lo <= ins_lo_wr ? csr_data : minstret_lo + {31'b0, retired};
      minstret_hi <= ins_hi_wr ? csr_data : minstret_hi + {31'b0, ins_carry};
    end
  end
`else
  logic unused_retired;
  assign unused_retired = retired;
`endif

  logic unused_ecp_low;
  assign unused_ecp_low = ^ecp[1:0];

  // NOTE: read_data gets a default before the case so no latch is inferred.
  always_comb begin
    read_data = '0;
    case (read_address)
      A_MSTATUS:  read_data = mstatus_rd;
      A_MISA:     read_data = MISA_VALUE;
      A_MIE:      read_data = mie_rd;
      A_MTVEC:    read_data = trap_vector;
      A_MSCRATCH: read_data = mscratch;
      A_MEPC:     read_data = mret_vector;
      A_MCAUSE:   read_data = mcause_rd;
      A_MIP:      read_data = mip_rd;
      A_MHARTID:  read_data = MHARTID;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: read_data = mcycle_lo;
      12'hB80, 12'hC80: read_data = mcycle_hi;
      12'hB02, 12'hC02: read_data = minstret_lo;
      12'hB82, 12'hC82: read_data = minstret_hi;
`endif
      default:    read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: reset values, masking, interrupt path, trap/mret
// priority, synchronous reset and (when CSR_COUNTERS_EN is defined) counters.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] read_address;
  logic [31:0] read_data;
  logic        csr_write;
  logic [11:0] csr_address;
  logic [31:0] csr_data;
  logic        traped, mret, retired;
  logic [31:0] ecp;
  logic [3:0]  ecause;
  logic        interupt;
  logic        ext_irq, timer_irq, soft_irq;
  logic        eip, tip, sip;
  logic [31:0] trap_vector, mret_vector;

  int checks = 0;
  int fails  = 0;

  always #50 clk = ~clk;

  csr_unit dut (
    .clk(clk), .reset(reset),
    .read_address(read_address), .read_data(read_data),
    .csr_write(csr_write), .csr_address(csr_address), .csr_data(csr_data),
    .traped(traped), .mret(mret), .retired(retired),
    .ecp(ecp), .ecause(ecause), .interupt(interupt),
    .ext_irq(ext_irq), .timer_irq(timer_irq), .soft_irq(soft_irq),
    .eip(eip), .tip(tip), .sip(sip),
    .trap_vector(trap_vector), .mret_vector(mret_vector)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    read_address = addr;
    #1;
    check(tag, read_data, exp);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    csr_write   = 1'b1;
    csr_address = addr;
    csr_data    = data;
    tick();
    csr_write   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; read_address = '0; csr_write = 1'b0; csr_address = '0; csr_data = '0;
    traped = 1'b0; mret = 1'b0; retired = 1'b0; ecp = '0; ecause = '0; interupt = 1'b0;
    ext_irq = 1'b0; timer_irq = 1'b0; soft_irq = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_sip", 32'(sip), 32'd0);
    check("rst_tip", 32'(tip), 32'd0);
    check("rst_eip", 32'(eip), 32'd0);
    check("rst_trap_vector", trap_vector, 32'd0);
    check("rst_mret_vector", mret_vector, 32'd0);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mie", 12'h304, 32'd0);
    rd("rst_mepc", 12'h341, 32'd0);
    rd("misa", 12'h301, 32'h4000_0100);
    rd("mhartid", 12'hF14, 32'd0);
    rd("unmapped", 12'h7C0, 32'd0);

    // Masking and plain read/write
    wr(12'h305, 32'h8000_0103);
    rd("mtvec_rd", 12'h305, 32'h8000_0100);
    check("trap_vector", trap_vector, 32'h8000_0100);
    wr(12'h341, 32'h0000_1237);
    rd("mepc_rd", 12'h341, 32'h0000_1234);
    check("mret_vector", mret_vector, 32'h0000_1234);
    wr(12'h340, 32'hDEAD_BEEF);
    rd("mscratch", 12'h340, 32'hDEAD_BEEF);
    wr(12'h301, 32'h0);
    rd("misa_ro", 12'h301, 32'h4000_0100);
    wr(12'h342, 32'hFFFF_FFFB);
    rd("mcause_mask", 12'h342, 32'h8000_000B);

    // Timer interrupt path
    wr(12'h300, 32'h0000_0008);
    wr(12'h304, 32'h0000_0080);
    rd("mstatus_mie", 12'h300, 32'h0000_1808);
    timer_irq = 1'b1;
    check("tip_before_sync", 32'(tip), 32'd0);
    tick();
    check("tip_set", 32'(tip), 32'd1);
    check("eip_masked", 32'(eip), 32'd0);
    rd("mip_mtip", 12'h344, 32'h0000_0080);

    // Trap entry
    traped = 1'b1; ecp = 32'h0000_2003; interupt = 1'b1; ecause = 4'd7;
    tick();
    traped = 1'b0; interupt = 1'b0; ecause = 4'd0;
    rd("trap_mepc", 12'h341, 32'h0000_2000);
    rd("trap_mcause", 12'h342, 32'h8000_0007);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    check("trap_tip_drop", 32'(tip), 32'd0);
    check("trap_mret_vector", mret_vector, 32'h0000_2000);

    // mret
    mret = 1'b1;
    tick();
    mret = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    check("mret_tip", 32'(tip), 32'd1);

    // Trap and mstatus write in the same cycle: trap wins
    traped = 1'b1; ecp = 32'h0000_3000; ecause = 4'd2;
    wr(12'h300, 32'h0);
    traped = 1'b0;
    rd("trap_vs_write", 12'h300, 32'h0000_1880);
    rd("trap_vs_write_mcause", 12'h342, 32'h0000_0002);

    // mret and mstatus write in the same cycle: mret wins
    mret = 1'b1;
    wr(12'h300, 32'h0);
    mret = 1'b0;
    rd("mret_vs_write", 12'h300, 32'h0000_1888);

    // External interrupt with timer disabled
    wr(12'h304, 32'h0000_0800);
    ext_irq = 1'b1;
    tick();
    check("eip_set", 32'(eip), 32'd1);
    check("tip_disabled", 32'(tip), 32'd0);
    check("sip_idle", 32'(sip), 32'd0);

`ifdef CSR_COUNTERS_EN
    wr(12'hB00, 32'hFFFF_FFFE);
    wr(12'hB80, 32'h0);
    tick();
    rd("mcycleh_carry", 12'hB80, 32'd1);
    rd("mcycle_wrap", 12'hB00, 32'd0);
    rd("cycleh_alias", 12'hC80, 32'd1);
    rd("minstret_idle", 12'hB02, 32'd0);
    retired = 1'b1;
    repeat (5) tick();
    retired = 1'b0;
    rd("minstret_5", 12'hB02, 32'd5);
    rd("instret_alias", 12'hC02, 32'd5);
    retired = 1'b1;
    wr(12'hB02, 32'd100);
    retired = 1'b0;
    rd("minstret_write_wins", 12'hB02, 32'd100);
    wr(12'hB02, 32'hFFFF_FFFF);
    retired = 1'b1;
    tick();
    retired = 1'b0;
    rd("minstret_wrap", 12'hB02, 32'd0);
    rd("minstreth_carry", 12'hB82, 32'd1);
`else
    wr(12'hB00, 32'h1234_5678);
    retired = 1'b1;
    tick();
    retired = 1'b0;
    rd("no_mcycle", 12'hB00, 32'd0);
    rd("no_mcycleh", 12'hB80, 32'd0);
    rd("no_minstret", 12'hB02, 32'd0);
    rd("no_minstreth", 12'hB82, 32'd0);
    rd("no_cycle", 12'hC00, 32'd0);
    rd("no_cycleh", 12'hC80, 32'd0);
    rd("no_instret", 12'hC02, 32'd0);
    rd("no_instreth", 12'hC82, 32'd0);
`endif

    // Synchronous reset mid-operation, with a simultaneous trap ignored
    reset = 1'b1; traped = 1'b1; ecp = 32'h0000_4000;
    tick();
    reset = 1'b0; traped = 1'b0;
    rd("mid_rst_mstatus", 12'h300, 32'h0000_1800);
    rd("mid_rst_mepc", 12'h341, 32'd0);
    rd("mid_rst_mcause", 12'h342, 32'd0);
    rd("mid_rst_mscratch", 12'h340, 32'd0);
    check("mid_rst_trap_vector", trap_vector, 32'd0);
    check("mid_rst_eip", 32'(eip), 32'd0);
`ifdef CSR_COUNTERS_EN
    rd("mid_rst_minstreth", 12'hB82, 32'd0);
`endif
    ext_irq = 1'b0; timer_irq = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode control/status register file for the 5-stage core. Sits beside the pipeline as the other end of the writeback stage's CSR/trap interface: takes CSR writes, trap and mret events, and retire pulses from writeback, and returns pending-interrupt requests (`sip`/`tip`/`eip`), trap target and mret target to fetch/writeback. Also provides a combinational read port for CSR instructions in execute.

## Interface
- `MHARTID`, default 0: value returned by mhartid (0xF14).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `read_address`  in  12  CSR read address.
- `read_data`  out  32  combinational read data.
- `csr_write`  in  1  commit write of `csr_data` to `csr_address`.
- `csr_address`  in  12  write address.
- `csr_data`  in  32  write data.
- `traped`  in  1  trap taken this cycle.
- `mret`  in  1  mret committed this cycle.
- `retired`  in  1  one instruction retired this cycle.
- `ecp`  in  32  exception PC to save into mepc.
- `ecause`  in  4  cause code.
- `interupt`  in  1  cause is an interrupt.
- `ext_irq`, `timer_irq`, `soft_irq`  in  1 each  level-sensitive platform interrupt lines.
- `eip`, `tip`, `sip`  out  1 each  enabled pending external/timer/software interrupt.
- `trap_vector`  out  32  `{mtvec[31:2],2'b00}`.
- `mret_vector`  out  32  mepc.

## Operation
- Implemented CSRs: mstatus 0x300 (MIE bit3, MPIE bit7, MPP 12:11 reads 2'b11, other bits 0); misa 0x301 read-only 0x40000100 (RV32I); mie 0x304 (MSIE 3, MTIE 7, MEIE 11, other bits 0); mtvec 0x305 (bits 1:0 read 0, direct mode only); mscratch 0x340; mepc 0x341 (bits 1:0 read 0); mcause 0x342 (bit31 + bits 3:0, others 0); mip 0x344 read-only; mvendorid/marchid/mimpid 0xF11-0xF13 read 0; mhartid 0xF14 reads `MHARTID`.
- Counters (see Configuration): mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82 writable; cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82 read-only aliases.
- Any other address reads 0; writes to it or to read-only CSRs are ignored.
- mip: MSIP/MTIP/MEIP bits are registered copies of `soft_irq`/`timer_irq`/`ext_irq`.
- `eip = mip.MEIP & mie.MEIE & mstatus.MIE`; `tip`, `sip` likewise. Combinational from registers only.
- Trap (`traped`=1): mepc <= `{ecp[31:2],2'b00}`; mcause <= `{interupt,27'b0,ecause}`; MPIE <= MIE; MIE <= 0.
- mret (`mret`=1, `traped`=0): MIE <= MPIE; MPIE <= 1.
- Priority per cycle: `traped` > `mret` > `csr_write` for fields touched by more than one; `csr_write` to mstatus in the same cycle as trap/mret is dropped.
- mcycle increments by 1 every cycle; minstret increments by 1 when `retired`. 64-bit counters; low-half wrap 0xFFFFFFFF -> 0 carries into high half same cycle.
- Software write to a counter half wins over increment that cycle: written half takes `csr_data` exactly; other half still increments/carries normally (carry from a half being written is suppressed).

## Timing
- Reset values: mstatus MIE=0, MPIE=0; mie=0; mip=0; mtvec=0; mscratch=0; mepc=0; mcause=0; counters=0. Outputs after reset: `sip`=`tip`=`eip`=0, `trap_vector`=0, `mret_vector`=0.
- Reads: zero latency; a write is visible on `read_data` the cycle after `csr_write`.
- IRQ line to `*ip` output: 1 cycle (mip register).
- After `traped`, MIE=0 from next cycle, so `*ip` outputs drop one cycle after the trap; no back-to-back interrupt trap.
- Reset asserted mid-operation: all state returns to reset values on the next edge; simultaneous trap/write ignored.

## Configuration
- `CSR_COUNTERS_EN` defined: mcycle/minstret and aliases implemented as above.
- Undefined: no counter flops; all eight counter addresses read 0, writes ignored; `retired` unused.

## Test plan
- Reset, read 0x300/0x304/0x341/0x301 -> 0x00001800, 0, 0, 0x40000100.
- Write mtvec 0x80000103, then read -> 0x80000100, `trap_vector`=0x80000100; write mepc 0x1237 -> read 0x1234.
- mstatus=0x8, mie=0x80, assert `timer_irq` -> `tip`=1 one cycle later; pulse `traped` with ecp=0x2000, interupt=1, ecause=7 -> mepc=0x2000, mcause=0x80000007, mstatus=0x1880, `tip`=0 next cycle; `mret` -> mstatus=0x1888.
- Same cycle `traped` and `csr_write` of mstatus=0x0 with MIE=1 -> trap update wins, MPIE=1, MIE=0.
- Write mcycle=0xFFFFFFFE, mcycleh=0 -> two cycles later mcycleh=1, mcycle=0; pulse `retired` 5 cycles -> minstret +5; without `CSR_COUNTERS_EN` all read 0.
